// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: FIFO-buffered WR sequencer for the shared FIR core; result valid FIR_LAT+3 cycles after accept.
// iREADY drops on FIFO full or flush; oDATA holds until iOUT_READY. Zero-write flush built only with FIR_CTRL_FLUSH_EN.
module fir_stream_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIR_LAT    = 1,
   parameter int TAPS       = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        iVALID,
   output logic        iREADY,
   input  logic [15:0] iSAMPLE,
   input  logic        iFLUSH,
   output logic        oWR,
   output logic [15:0] oFIR_DATA,
   input  logic [38:0] iFIR_DATA,
   output logic        oVALID,
   input  logic        iOUT_READY,
   output logic [38:0] oDATA,
   output logic        oBUSY
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CMAX = (TAPS > FIR_LAT) ? TAPS : FIR_LAT;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WRITE, ST_WAIT, ST_HOLD, ST_FLUSH, ST_FLUSH_WAIT
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic          r_alive;
   logic          r_wr;
   logic [15:0]   r_fir_data;
   logic          r_valid;
   logic [38:0]   r_data;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_clr;
   logic          w_leave;
   logic          w_flush_blk;

   assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_leave = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && iOUT_READY);

`ifdef FIR_CTRL_FLUSH_EN
   logic          r_busy;
   logic          r_flush_pend;

   assign w_flush_blk = r_flush_pend || r_busy;
   assign w_clr       = w_leave && r_flush_pend;
   assign oBUSY       = r_busy;
`else
   logic          w_unused_flush;

   assign w_unused_flush = iFLUSH;
   assign w_flush_blk    = 1'b0;
   assign w_clr          = 1'b0;
   assign oBUSY          = 1'b0;
`endif

   // Full is taken from the registered count, so a pop cannot make room for a push in the same cycle.
   assign iREADY    = r_alive && !w_full && !w_flush_blk;
   assign w_push    = iVALID && iREADY;
   assign w_pop     = w_leave && !w_empty && !w_clr;
   assign oWR       = r_wr;
   assign oFIR_DATA = r_fir_data;
   assign oVALID    = r_valid;
   assign oDATA     = r_data;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_clr) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + (AW+1)'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push)
         r_mem[r_wr_ptr] <= iSAMPLE;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_alive    <= 1'b0;
         r_wr       <= 1'b0;
         r_fir_data <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
`ifdef FIR_CTRL_FLUSH_EN
         r_busy       <= 1'b0;
         r_flush_pend <= 1'b0;
`endif
      end else begin
         r_alive <= 1'b1;
`ifdef FIR_CTRL_FLUSH_EN
         if (w_clr)
            r_flush_pend <= 1'b0;
         else if (iFLUSH && !r_busy)
            r_flush_pend <= 1'b1;
`endif
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (w_leave) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
`ifdef FIR_CTRL_FLUSH_EN
                  // A pending flush wins over queued data; the FIFO is cleared on this same edge.
                  if (r_flush_pend) begin
                     r_state <= ST_FLUSH;
                     r_cnt   <= CW'(TAPS - 1);
                     r_wr    <= 1'b1;
                     r_busy  <= 1'b1;
                  end else
`endif
                  if (!w_empty) begin
                     r_state    <= ST_WRITE;
                     r_wr       <= 1'b1;
                     r_fir_data <= r_mem[r_rd_ptr];
                  end
               end
            end
            ST_WRITE: begin
               r_wr       <= 1'b0;
               r_fir_data <= '0;
               r_cnt      <= CW'(FIR_LAT - 1);
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_data  <= iFIR_DATA;
                  r_valid <= 1'b1;
                  r_state <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
`ifdef FIR_CTRL_FLUSH_EN
            ST_FLUSH: begin
               if (r_cnt == '0) begin
                  r_wr    <= 1'b0;
                  r_cnt   <= CW'(FIR_LAT - 1);
                  r_state <= ST_FLUSH_WAIT;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_FLUSH_WAIT: begin
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: x3 core model, queue scoreboard under random traffic, directed latency/flush/reset cases.
module tb_fir_stream_ctrl;
   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        iVALID = 1'b0;
   logic        iFLUSH = 1'b0;
   logic        iOUT_READY = 1'b0;
   logic [15:0] iSAMPLE = '0;
   logic        iREADY;
   logic        oWR;
   logic        oVALID;
   logic        oBUSY;
   logic [15:0] oFIR_DATA;
   logic [38:0] iFIR_DATA;
   logic [38:0] oDATA;
   logic [38:0] core_q;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_out = 0;
   bit          mon_en = 1'b1;
   logic [15:0] pend_q[$];
   logic [63:0] res_q[$];

   fir_stream_ctrl #(.FIFO_DEPTH(4), .FIR_LAT(1), .TAPS(8)) dut (
      .CLK(CLK), .RESET(RESET), .iVALID(iVALID), .iREADY(iREADY), .iSAMPLE(iSAMPLE),
      .iFLUSH(iFLUSH), .oWR(oWR), .oFIR_DATA(oFIR_DATA), .iFIR_DATA(iFIR_DATA),
      .oVALID(oVALID), .iOUT_READY(iOUT_READY), .oDATA(oDATA), .oBUSY(oBUSY)
   );

   always #5 CLK = ~CLK;

   // Core stand-in: result is 3x the written sample, one cycle after WR.
   always @(posedge CLK or negedge RESET) begin
      if (!RESET)
         core_q <= '0;
      else if (oWR)
         core_q <= 39'(oFIR_DATA) * 39'd3;
   end
   assign iFIR_DATA = core_q;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard: accepted samples must be written in order, and each result must be 3x its sample.
   initial begin
      logic [63:0] hold_d;
      logic [15:0] s;
      bit          hold_v;
      hold_v = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge CLK);
         if (!RESET || !mon_en) begin
            if (!RESET) begin
               pend_q.delete();
               res_q.delete();
            end
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               check("hold_vld", 64'(oVALID), 64'd1);
               check("hold_dat", 64'(oDATA), hold_d);
            end
            if (oWR) begin
               check("wr_overlap", 64'(oVALID), 64'd0);
               check("wr_underflow", 64'(pend_q.size() != 0), 64'd1);
               if (pend_q.size() != 0) begin
                  s = pend_q.pop_front();
                  check("wr_dat", 64'(oFIR_DATA), 64'(s));
                  res_q.push_back(64'(s) * 64'd3);
               end
            end else begin
               check("wr_idle_dat", 64'(oFIR_DATA), 64'd0);
            end
            hold_v = 1'b0;
            if (oVALID) begin
               if (iOUT_READY) begin
                  check("out_underflow", 64'(res_q.size() != 0), 64'd1);
                  if (res_q.size() != 0)
                     check("out_dat", 64'(oDATA), res_q.pop_front());
                  n_out++;
               end else begin
                  hold_v = 1'b1;
                  hold_d = 64'(oDATA);
               end
            end
            if (iVALID && iREADY)
               pend_q.push_back(iSAMPLE);
         end
      end
   end

   task automatic drain(input string tag);
      int i = 0;
      iVALID = 1'b0;
      iFLUSH = 1'b0;
      iOUT_READY = 1'b1;
      while (i < 300 && !(pend_q.size() == 0 && res_q.size() == 0 && !oVALID && !oWR && !oBUSY)) begin
         tick();
         i++;
      end
      tick();
      check({tag, "_drain"}, 64'(pend_q.size() + res_q.size()), 64'd0);
   endtask

   task automatic single_lat(input logic [15:0] s, input string tag);
      int          wr_c = -1;
      int          v_c = -1;
      int          nv = 0;
      logic [15:0] wd = '0;
      logic [38:0] vd = '0;
      iOUT_READY = 1'b1;
      iVALID = 1'b1;
      iSAMPLE = s;
      check({tag, "_rdy"}, 64'(iREADY), 64'd1);
      tick();
      iVALID = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (oWR && wr_c < 0) begin
            wr_c = c;
            wd = oFIR_DATA;
         end
         if (oVALID) begin
            if (v_c < 0) begin
               v_c = c;
               vd = oDATA;
            end
            nv++;
         end
         tick();
      end
      check({tag, "_wr_cyc"}, 64'(wr_c), 64'd2);
      check({tag, "_wr_dat"}, 64'(wd), 64'(s));
      check({tag, "_vld_cyc"}, 64'(v_c), 64'd4);
      check({tag, "_vld_dat"}, 64'(vd), 64'(s) * 64'd3);
      check({tag, "_vld_cnt"}, 64'(nv), 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int k;
      int n0;
      int last;
      int nz;
      int nwr;
      int nb;
      int nv;
      int rdy_seen;

      // Reset held with traffic offered
      iVALID = 1'b1;
      iSAMPLE = 16'h5555;
      for (int c = 0; c < 3; c++) tick();
      check("rst_rdy", 64'(iREADY), 64'd0);
      check("rst_outs", 64'({oWR, oVALID, oBUSY}), 64'd0);
      check("rst_data", 64'({oFIR_DATA, oDATA}), 64'd0);
      iVALID = 1'b0;
      RESET = 1'b1;
      tick();
      check("rel_rdy", 64'(iREADY), 64'd1);
      nwr = 0;
      for (int c = 0; c < 4; c++) begin
         if (oWR) nwr++;
         tick();
      end
      check("rel_no_wr", 64'(nwr), 64'd0);

      single_lat(16'h1234, "single");

      // Backpressure: 5 accepted then full
      iOUT_READY = 1'b0;
      acc = 0;
      n0 = n_out;
      for (int i = 0; i < 7; i++) begin
         iVALID = 1'b1;
         iSAMPLE = 16'h0100 + 16'(acc);
         if (iREADY) acc++;
         tick();
      end
      check("bp_accepted", 64'(acc), 64'd5);
      check("bp_rdy_low", 64'(iREADY), 64'd0);
      iOUT_READY = 1'b1;
      k = 0;
      while (acc < 7 && k < 100) begin
         iVALID = 1'b1;
         iSAMPLE = 16'h0100 + 16'(acc);
         if (iREADY) acc++;
         tick();
         k++;
      end
      drain("bp");
      check("bp_results", 64'(n_out - n0), 64'd7);

      // Streaming: one result every FIR_LAT+2 cycles
      last = -1;
      iOUT_READY = 1'b1;
      for (int c = 0; c < 45; c++) begin
         iVALID = 1'b1;
         iSAMPLE = 16'($urandom);
         if (oVALID) begin
            if (last >= 0) check("stream_gap", 64'(c - last), 64'd3);
            last = c;
         end
         tick();
      end
      drain("stream");

      // Random traffic against the scoreboard
      n0 = n_out;
      for (int c = 0; c < 500; c++) begin
         iVALID = ($urandom_range(0, 3) != 0);
         iSAMPLE = 16'($urandom);
         iOUT_READY = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain("rand");
      check("rand_some", 64'(n_out > n0 + 50), 64'd1);

      // Flush requested in HOLD with two samples queued
`ifdef FIR_CTRL_FLUSH_EN
      mon_en = 1'b0;
`endif
      iOUT_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iVALID = 1'b1;
         iSAMPLE = 16'h0A00 + 16'(i);
         check("fl_push_rdy", 64'(iREADY), 64'd1);
         tick();
      end
      iVALID = 1'b0;
      k = 0;
      while (!oVALID && k < 20) begin
         tick();
         k++;
      end
      check("fl_hold_dat", 64'(oDATA), 64'h1E00);
      iFLUSH = 1'b1;
      tick();
      iFLUSH = 1'b0;
`ifdef FIR_CTRL_FLUSH_EN
      check("fl_pend_rdy", 64'(iREADY), 64'd0);
`else
      check("fl_pend_rdy", 64'(iREADY), 64'd1);
`endif
      check("fl_hold_kept", 64'(oVALID), 64'd1);
      iOUT_READY = 1'b1;
      tick();
      nz = 0; nwr = 0; nb = 0; nv = 0; rdy_seen = 0;
      for (int c = 0; c < 16; c++) begin
         if (oWR) nwr++;
         if (oWR && oFIR_DATA == 16'd0) nz++;
         if (oBUSY) nb++;
         if (oVALID) nv++;
         if (!oBUSY && nb > 0 && rdy_seen == 0) begin
            rdy_seen = 1;
            check("fl_rdy_back", 64'(iREADY), 64'd1);
         end
         tick();
      end
`ifdef FIR_CTRL_FLUSH_EN
      check("fl_zero_wr", 64'(nz), 64'd8);
      check("fl_all_wr", 64'(nwr), 64'd8);
      check("fl_busy", 64'(nb), 64'd9);
      check("fl_no_vld", 64'(nv), 64'd0);
      check("fl_rdy_seen", 64'(rdy_seen), 64'd1);
      pend_q.delete();
      res_q.delete();
      mon_en = 1'b1;
`else
      check("fl_zero_wr", 64'(nz), 64'd0);
      check("fl_busy", 64'(nb), 64'd0);
      check("fl_all_wr", 64'(nwr), 64'd2);
      check("fl_vld", 64'(nv), 64'd2);
`endif
      drain("flush");

      // Reset asserted while in WAIT
      iOUT_READY = 1'b1;
      iVALID = 1'b1;
      iSAMPLE = 16'h0ABC;
      tick();
      iVALID = 1'b0;
      tick();
      check("rw_wr", 64'(oWR), 64'd1);
      tick();
      check("rw_in_wait", 64'({oWR, oVALID}), 64'd0);
      RESET = 1'b0;
      #1;
      check("rw_rst_outs", 64'({oWR, oVALID, oBUSY, iREADY}), 64'd0);
      check("rw_rst_data", 64'({oFIR_DATA, oDATA}), 64'd0);
      tick();
      tick();
      RESET = 1'b1;
      tick();
      check("rw_rel_rdy", 64'(iREADY), 64'd1);
      nv = 0;
      nwr = 0;
      for (int c = 0; c < 8; c++) begin
         if (oVALID) nv++;
         if (oWR) nwr++;
         tick();
      end
      check("rw_no_vld", 64'(nv), 64'd0);
      check("rw_fifo_empty", 64'(nwr), 64'd0);
      single_lat(16'h0222, "rw_new");
      drain("end");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
